// File: rtl/busreq_pkg.sv
// Shared types and sizing for the bus-request register file and its operand FIFO.
package busreq_pkg;

    localparam int FIFO_DEPTH = 8;
    localparam int NUM_REGS   = 16;
    localparam int DATA_W     = 4;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;

    typedef enum logic [3:0] {
        REQ_IDLE  = 4'b0000,
        REQ_READ  = 4'b0001,
        REQ_WRITE = 4'b0010,
        REQ_NEXT  = 4'b0011
    } busreq_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/operand_fifo.sv
// Operand FIFO: wrapping pointers, registered full/empty, single-cycle overflow/underflow pulses.
module operand_fifo
    import busreq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic              underflow
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;
    logic              do_push;
    logic              do_pop;

    // A pop frees a slot in the same edge, so a full FIFO can still take a push alongside it.
    assign do_pop    = pop && (count != '0);
    assign do_push   = push && ((count != CNT_W'(FIFO_DEPTH)) || do_pop);
    assign underflow = pop && (count == '0);
    assign overflow  = push && !do_push;
    assign count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
    assign pop_data  = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(FIFO_DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // NOTE: storage is not reset; count and pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/busreq_regfile.sv
// Register file serviced by a two-state request/acknowledge handshake from the ALU core.
module busreq_regfile
    import busreq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        busreq,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              op_push,
    input  logic [DATA_W-1:0] op_in,
    output logic [DATA_W-1:0] operand,
    output logic [DATA_W-1:0] reg_data,
    output logic              ack,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              err
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    state_e            state;
    state_e            state_nxt;
    logic              exec;
    logic              do_read;
    logic              do_write;
    logic              do_next;
    logic [DATA_W-1:0] pop_data;
    logic              overflow;
    logic              underflow;

    operand_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (op_push),
        .pop       (do_next),
        .push_data (op_in),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        exec      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (busreq inside {REQ_READ, REQ_WRITE, REQ_NEXT}) begin
                    exec      = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (busreq == REQ_IDLE) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign do_read  = exec && (busreq == REQ_READ);
    assign do_write = exec && (busreq == REQ_WRITE) && (operand != '0);
    assign do_next  = exec && (busreq == REQ_NEXT);

    always_ff @(posedge clk) begin
        if (rst) begin
            ack      <= 1'b0;
            operand  <= '0;
            reg_data <= '0;
            err      <= 1'b0;
        end else begin
            ack <= (state_nxt == ST_HOLD);
            err <= err | overflow | underflow;
            if (do_next && !fifo_empty) operand <= pop_data;
            if (do_read) reg_data <= (operand == '0) ? '0 : regs[operand];
        end
    end

    // Register contents are architecturally visible after reset, so the array is cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (do_write) begin
            regs[operand] <= wb_data;
        end
    end

endmodule

// File: tb/tb_busreq_regfile.sv
// Directed self-checking bench for busreq_regfile with hand-computed expectations.
module tb_busreq_regfile;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] busreq;
    logic [3:0] wb_data;
    logic       op_push;
    logic [3:0] op_in;
    logic [3:0] operand;
    logic [3:0] reg_data;
    logic       ack;
    logic       fifo_full;
    logic       fifo_empty;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;

    busreq_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .busreq     (busreq),
        .wb_data    (wb_data),
        .op_push    (op_push),
        .op_in      (op_in),
        .operand    (operand),
        .reg_data   (reg_data),
        .ack        (ack),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Issue one request and release it, leaving the FSM back in IDLE.
    task automatic request(input logic [3:0] code);
        busreq = code;
        tick();
        busreq = 4'b0000;
        tick();
    endtask

    initial begin
        busreq  = 4'b0000;
        wb_data = 4'd0;
        op_push = 1'b0;
        op_in   = 4'd0;
        rst     = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ack",   ack, 0);
        check("rst_op",    operand, 0);
        check("rst_rdata", reg_data, 0);
        check("rst_err",   err, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_full",  fifo_full, 0);

        // Push 1, NEXT, release.
        op_push = 1'b1; op_in = 4'd1; tick(); op_push = 1'b0;
        check("push1_empty", fifo_empty, 0);
        busreq = 4'b0011; tick();
        check("next_op",  operand, 1);
        check("next_ack", ack, 1);
        check("next_empty", fifo_empty, 1);
        busreq = 4'b0000; tick();
        check("release_ack", ack, 0);

        // WRITE 4 to R1, then READ it back; a code change while in HOLD is ignored.
        wb_data = 4'd4; request(4'b0010);
        busreq = 4'b0001; tick();
        check("read_r1",  reg_data, 4);
        check("read_ack", ack, 1);
        wb_data = 4'd9; busreq = 4'b0010; tick();
        check("hold_ack", ack, 1);
        busreq = 4'b0000; tick();
        busreq = 4'b0001; tick();
        check("hold_nowrite", reg_data, 4);
        busreq = 4'b0000; tick();

        // Undefined codes produce no ack.
        busreq = 4'b0101; tick();
        check("bad_code_ack", ack, 0);
        busreq = 4'b1111; tick();
        check("bad_code_ack2", ack, 0);
        busreq = 4'b0000; tick();

        // Nine pushes 0..8: full after eight, ninth dropped with err.
        for (int i = 0; i < 9; i++) begin
            op_push = 1'b1; op_in = 4'(i); tick();
            if (i == 7) begin
                check("fill_full", fifo_full, 1);
                check("fill_err",  err, 0);
            end
        end
        op_push = 1'b0;
        check("ovf_full", fifo_full, 1);
        check("ovf_err",  err, 1);
        for (int i = 0; i < 8; i++) begin
            busreq = 4'b0011; tick();
            check($sformatf("drain_op%0d", i), operand, 4'(i));
            busreq = 4'b0000; tick();
        end
        check("drain_empty", fifo_empty, 1);
        check("drain_full",  fifo_full, 0);

        // Full FIFO with simultaneous push and pop: both succeed.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            op_push = 1'b1; op_in = 4'(8 + i); tick();
        end
        op_in = 4'd3; busreq = 4'b0011; tick(); op_push = 1'b0;
        check("fullpp_op",   operand, 8);
        check("fullpp_full", fifo_full, 1);
        check("fullpp_err",  err, 0);
        busreq = 4'b0000; tick();
        for (int i = 1; i < 8; i++) request(4'b0011);
        check("fullpp_op15", operand, 15);
        request(4'b0011);
        check("fullpp_last", operand, 3);
        check("fullpp_empty", fifo_empty, 1);
        check("fullpp_err2",  err, 0);

        // Empty FIFO NEXT with operand=5: operand held, err set, ack asserted; push alongside is kept.
        do_reset();
        op_push = 1'b1; op_in = 4'd5; tick(); op_push = 1'b0;
        request(4'b0011);
        check("op5", operand, 5);
        op_push = 1'b1; op_in = 4'd6; busreq = 4'b0011; tick(); op_push = 1'b0;
        check("unf_op",    operand, 5);
        check("unf_err",   err, 1);
        check("unf_ack",   ack, 1);
        check("unf_empty", fifo_empty, 0);
        busreq = 4'b0000; tick();
        request(4'b0011);
        check("unf_pushed", operand, 6);

        // R0 ignores writes.
        do_reset();
        wb_data = 4'd7; request(4'b0010);
        busreq = 4'b0001; tick();
        check("r0_read", reg_data, 0);
        check("r0_ack",  ack, 1);
        busreq = 4'b0000; tick();

        // Reset in HOLD aborts; held NEXT re-executes exactly once afterwards.
        op_push = 1'b1; op_in = 4'd2; tick(); op_push = 1'b0;
        busreq = 4'b0011; tick();
        check("pre_rst_op", operand, 2);
        rst = 1'b1; tick();
        check("mid_rst_ack",   ack, 0);
        check("mid_rst_op",    operand, 0);
        check("mid_rst_empty", fifo_empty, 1);
        check("mid_rst_err",   err, 0);
        rst = 1'b0; tick();
        check("reexec_ack", ack, 1);
        check("reexec_err", err, 1);
        op_push = 1'b1; op_in = 4'd9; tick(); op_push = 1'b0;
        tick();
        check("once_op",    operand, 0);
        check("once_empty", fifo_empty, 0);
        busreq = 4'b0000; tick();
        check("once_release", ack, 0);
        request(4'b0011);
        check("once_pop9", operand, 9);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/busreq_regfile.md
BUSREQ_REGFILE -- requirements
Module: busreq_regfile

Interface
REQ-001 clk  in  1  rising-edge clock; sole clock domain.
REQ-002 rst  in  1  reset; synchronous, active-high.
REQ-003 busreq  in  4  bus request code driven by the ALU core.
REQ-004 wb_data  in  4  ALU result to be written back on a WRITE request.
REQ-005 op_push  in  1  host strobe; pushes op_in into the operand FIFO.
REQ-006 op_in  in  4  register index pushed by the host.
REQ-007 operand  out  4  current operand register index, wired to the core's operand field.
REQ-008 reg_data  out  4  register value returned on a READ request.
REQ-009 ack  out  1  request serviced; high until busreq returns to 0000.
REQ-010 fifo_full  out  1  operand FIFO holds 8 entries.
REQ-011 fifo_empty  out  1  operand FIFO holds 0 entries.
REQ-012 err  out  1  sticky flag for FIFO overflow or underflow; cleared only by rst.

Function
REQ-013 The block SHALL hold 16 x 4-bit registers; R0 SHALL always read 0, and writes to R0 SHALL be ignored.
REQ-014 The block SHALL hold an 8-deep x 4-bit operand FIFO with 3-bit wrapping read/write pointers and a 4-bit count (0..8).
REQ-015 Request codes SHALL be: 0000 IDLE, 0001 READ, 0010 WRITE, 0011 NEXT; all other codes SHALL cause no action and no ack.
REQ-016 The FSM SHALL have two states, IDLE and HOLD.
- IDLE: a valid code sampled at edge N is executed at edge N; ack=1 after edge N; next state HOLD.
- HOLD: no new request is executed; when busreq==0000, ack=0 after that edge and next state IDLE.
REQ-017 READ SHALL update reg_data <= regs[operand] at the executing edge (one-cycle latency); reg_data SHALL hold its value otherwise.
REQ-018 WRITE SHALL perform regs[operand] <= wb_data at the executing edge; a later READ of that register SHALL return the new value.
REQ-019 NEXT SHALL pop the FIFO head into operand.
- If the FIFO is empty: operand is unchanged, err is set, and ack is still asserted.
REQ-020 op_push SHALL be accepted at any FSM state.
- If full with no simultaneous pop: the push is dropped and err is set.
- If full with a simultaneous pop: both the push and the pop succeed.
- If empty with a simultaneous pop: the pop underflows (err set) and the push is stored.
REQ-021 fifo_full and fifo_empty SHALL be registered and reflect the count after each edge.
REQ-022 A busreq change while in HOLD to a different non-zero code SHALL be ignored until busreq has returned to 0000.

Reset
REQ-023 On rst high at an edge, the block SHALL reset the following: all registers=0, FIFO count=0, pointers=0, operand=0, reg_data=0, ack=0, err=0, fifo_empty=1, fifo_full=0, FSM=IDLE.
REQ-024 Reset asserted mid-request (in HOLD) SHALL abort the request; ack=0 after that edge; a held busreq SHALL be re-executed only once rst is low and the FSM is in IDLE.

Structure
REQ-025 A shared package busreq_pkg SHALL contain the busreq code enum, FIFO_DEPTH=8, NUM_REGS=16 and DATA_W=4.
REQ-026 The FIFO SHALL be a sub-module operand_fifo, with push, pop, data, full, empty and overflow/underflow pulses; the register array and FSM stay in busreq_regfile.

Verification
REQ-027 Push op_in=1, then busreq=0011 -> next cycle operand=1, ack=1; busreq=0000 -> next cycle ack=0.
REQ-028 With operand=1: wb_data=4, busreq=0010, release, then busreq=0001 -> reg_data=4, ack=1.
REQ-029 Nine pushes of values 0..8 -> fifo_full=1 after eight, ninth dropped, err=1; eight NEXT requests -> operand sequence 0..7, then fifo_empty=1.
REQ-030 NEXT with an empty FIFO and operand=5 -> operand stays 5, err=1, ack=1.
REQ-031 Operand=0: WRITE with wb_data=7, then READ -> reg_data=0.
REQ-032 rst pulsed while in HOLD with busreq=0011 held -> ack=0, operand=0, fifo_empty=1, err=0; after rst deasserts, the request re-executes once.
